// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_pkg
// Description : Shared definitions for the irrigation scheduler: the state
//               encoding (which is also the externally visible estado code),
//               default burst/rest timings and the round-robin pointer values.
// Revision    : 1.0 - initial release
// ============================================================================
package irrigation_pkg;

    // State codes double as the estado output seen by the display logic.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ASP   = 3'd1,
        ST_GOT   = 3'd2,
        ST_REST  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int T_ASP_DEF  = 30;
    localparam int T_GOT_DEF  = 60;
    localparam int T_REST_DEF = 10;
    localparam int CNT_W_DEF  = 8;

    // Round-robin pointer: names the side that wins the next contested grant.
    localparam logic PTR_ASP = 1'b0;
    localparam logic PTR_GOT = 1'b1;

endpackage : irrigation_pkg
`default_nettype wire

// File: rtl/irrigation_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_tick_timer
// Description : CNT_W-bit down-counter advanced by the timebase tick.
//               load has priority over clr, clr over decrement, so a tick on
//               the loading edge never eats into the freshly loaded value.
//               The counter saturates at 0; done flags the tick that moves
//               it from 1 to 0.
// Ports       : clock, Rst (async, active-high)
//               load/load_val : load a new interval
//               clr           : force count to 0
//               tick          : one-cycle decrement enable
//               count         : registered remaining ticks
//               done          : tick & (count == 1), combinational
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             Rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (clr) begin
            count_d = '0;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = tick && (count_q == CNT_W'(1));

endmodule : irrigation_tick_timer
`default_nettype wire

// File: rtl/irrigation_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_scheduler
// Description : Time-shares the water supply between the sprinkler pump (Bs)
//               and the drip valve (Vs). One burst at a time, each followed by
//               a mandatory rest; contested requests are served round-robin.
//               Any level error or critical tank level forces FAULT, which
//               always exits through a rest interval.
// Ports       : clock, Rst (async, active-high), tick (timebase enable)
//               req_asp, req_got : level-sensitive watering requests
//               erro, nv_critico : fault sources
//               Bs, Vs           : registered actuator commands
//               busy             : state is not IDLE
//               estado           : state code 0..4
//               restante         : ticks left in the timed state
//               ciclos           : completed-burst count (only with
//                                  IRRIG_CYCLE_COUNT_EN defined)
// Options     : `define IRRIG_CYCLE_COUNT_EN adds the ciclos output and its
//               saturating 8-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int T_ASP  = T_ASP_DEF,
    parameter int T_GOT  = T_GOT_DEF,
    parameter int T_REST = T_REST_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             Rst,
    input  logic             tick,
    input  logic             req_asp,
    input  logic             req_got,
    input  logic             erro,
    input  logic             nv_critico,
    output logic             Bs,
    output logic             Vs,
    output logic             busy,
    output logic [2:0]       estado,
    output logic [CNT_W-1:0] restante
`ifdef IRRIG_CYCLE_COUNT_EN
    ,
    output logic [7:0]       ciclos
`endif
);

    localparam logic [CNT_W-1:0] C_T_ASP  = CNT_W'(T_ASP);
    localparam logic [CNT_W-1:0] C_T_GOT  = CNT_W'(T_GOT);
    localparam logic [CNT_W-1:0] C_T_REST = CNT_W'(T_REST);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             bs_q, bs_d;
    logic             vs_q, vs_d;
    logic             busy_q, busy_d;

    logic             fault;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_clr;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_count;

    assign fault = erro | nv_critico;

    irrigation_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .Rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clr      (tmr_clr),
        .tick     (tick),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // ------------------------------------------------------------------
    // Next-state, arbitration and timer control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_clr  = 1'b0;

        if (fault) begin
            state_d = ST_FAULT;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_asp && req_got) begin
                        if (ptr_q == PTR_ASP) begin
                            state_d  = ST_ASP;
                            tmr_val  = C_T_ASP;
                            ptr_d    = PTR_GOT;
                        end else begin
                            state_d  = ST_GOT;
                            tmr_val  = C_T_GOT;
                            ptr_d    = PTR_ASP;
                        end
                        tmr_load = 1'b1;
                    end else if (req_asp) begin
                        state_d  = ST_ASP;
                        tmr_val  = C_T_ASP;
                        tmr_load = 1'b1;
                        ptr_d    = PTR_GOT;
                    end else if (req_got) begin
                        state_d  = ST_GOT;
                        tmr_val  = C_T_GOT;
                        tmr_load = 1'b1;
                        ptr_d    = PTR_ASP;
                    end
                end

                // Timeout and request drop both end the burst the same way.
                ST_ASP: begin
                    if (!req_asp || tmr_done) begin
                        state_d  = ST_REST;
                        tmr_val  = C_T_REST;
                        tmr_load = 1'b1;
                    end
                end

                ST_GOT: begin
                    if (!req_got || tmr_done) begin
                        state_d  = ST_REST;
                        tmr_val  = C_T_REST;
                        tmr_load = 1'b1;
                    end
                end

                // The final tick already takes the counter to 0.
                ST_REST: begin
                    if (tmr_done) begin
                        state_d = ST_IDLE;
                    end
                end

                // Reaching here means fault sampled low: recover via a rest.
                ST_FAULT: begin
                    state_d  = ST_REST;
                    tmr_val  = C_T_REST;
                    tmr_load = 1'b1;
                end

                default: begin
                    state_d = ST_IDLE;
                    tmr_clr = 1'b1;
                end
            endcase
        end

        // Actuators follow the next state so they switch with the state flop;
        // a single state drives each, so they can never both be high.
        bs_d   = (state_d == ST_ASP);
        vs_d   = (state_d == ST_GOT);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_ASP;
            bs_q    <= 1'b0;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bs_q    <= bs_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
        end
    end

    assign Bs       = bs_q;
    assign Vs       = vs_q;
    assign busy     = busy_q;
    assign estado   = state_q;
    assign restante = tmr_count;

`ifdef IRRIG_CYCLE_COUNT_EN
    // A burst completes on any burst->REST transition; fault aborts go to
    // FAULT instead and are therefore not counted.
    logic [7:0] ciclos_q, ciclos_d;
    logic       burst_end;

    assign burst_end = ((state_q == ST_ASP) || (state_q == ST_GOT)) &&
                       (state_d == ST_REST);

    always_comb begin
        ciclos_d = ciclos_q;
        if (burst_end && (ciclos_q != 8'hFF)) begin
            ciclos_d = ciclos_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            ciclos_q <= 8'd0;
        end else begin
            ciclos_q <= ciclos_d;
        end
    end

    assign ciclos = ciclos_q;
`endif

endmodule : irrigation_scheduler
`default_nettype wire
